// File: rtl/game_pkg.sv
// Shared types and helpers for the cell-grid game: line-select width, LFSR taps, one-hot decode.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents:
//   LINE_W        width of a one-hot row/column select
//   LFSR_TAPS     Galois feedback mask for the 16-bit move generator
//   seq_state_t   scramble sequencer states
//   move_t        latched move (row/column flag plus line index)
//   line_onehot   2-bit line index -> one-hot line select
//   lfsr_step     one Galois shift of a 16-bit LFSR
package game_pkg;

    localparam int          LINE_W    = 4;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_FIRE = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic       x_nrow;   // 0 = row, 1 = column
        logic [1:0] idx;      // which of the four lines
    } move_t;

    // Index 0 selects the lowest line: 00->0001, 01->0010, 10->0100, 11->1000.
    function automatic logic [LINE_W-1:0] line_onehot(input logic [1:0] idx);
        logic [LINE_W-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Right-shifting Galois form: the bit falling out of bit 0 is fed back
    // through the tap mask.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, advances once per clock in every state.
// Latency: q is the registered LFSR state; it changes on every rising clk edge.
// Backpressure: none; it never stalls.
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset; loads SEED
//   q      current LFSR state
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1   // must be nonzero or the register locks up
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= SEED;
        end else begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/scramble_sequencer.sv
// Scramble move generator in front of the grid select: user pass-through in idle, paced random moves on start.
// Latency: pass-through is combinational; busy rises the cycle after start, first fire STEP_CYCLES+1 cycles after start.
// Backpressure: none; while busy all user inputs including start are ignored, and start in DONE is dropped.
//
// Ports:
//   clk, reset                  clock and asynchronous active-low reset
//   start                       one-cycle scramble request (already edge-detected)
//   user_row_column/user_nRow   user line select and row/column flag
//   user_fire, user_error       user fire and invalid-selection flag
//   row_column/x_nRow/fire      selection presented to the grid
//   busy                        sequencer owns the grid (GAP or FIRE)
//   done                        one-cycle pulse after the final fire
//   move_count                  moves issued since the last accepted start
module scramble_sequencer
    import game_pkg::*;
#(
    parameter int          MOVES       = 32,       // 0..255
    parameter int          STEP_CYCLES = 16,       // 1..65535
    parameter logic [15:0] LFSR_SEED   = 16'hACE1  // nonzero
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LINE_W-1:0] user_row_column,
    input  logic              user_nRow,
    input  logic              user_fire,
    input  logic              user_error,
    output logic [LINE_W-1:0] row_column,
    output logic              x_nRow,
    output logic              fire,
    output logic              busy,
    output logic              done,
    output logic [7:0]        move_count
);

    localparam logic [7:0]  MOVES_INIT   = 8'(MOVES);
    localparam logic [15:0] TIMER_RELOAD = 16'(STEP_CYCLES - 1);

    seq_state_t  state;
    seq_state_t  state_nxt;
    logic [15:0] timer;
    logic [7:0]  remaining;
    move_t       move;
    logic [15:0] lfsr_q;
    logic        lfsr_unused;

    // Only the low three bits pick a move; the rest just keep the sequence long.
    assign lfsr_unused = ^lfsr_q[15:3];

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    // A zero-move scramble still reports completion.
                    state_nxt = (MOVES_INIT == 8'd0) ? ST_DONE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (timer == 16'd0) begin
                    state_nxt = ST_FIRE;
                end
            end
            ST_FIRE: begin
                state_nxt = (remaining == 8'd1) ? ST_DONE : ST_GAP;
            end
            ST_DONE: begin
                // start arriving here is deliberately dropped.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Timer, move latch and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer      <= 16'd0;
            remaining  <= 8'd0;
            move_count <= 8'd0;
            move       <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        move_count <= 8'd0;
                        remaining  <= MOVES_INIT;
                        move       <= move_t'(lfsr_q[2:0]);
                        timer      <= TIMER_RELOAD;
                    end
                end
                ST_GAP: begin
                    if (timer != 16'd0) begin
                        timer <= timer - 16'd1;
                    end
                end
                ST_FIRE: begin
                    move_count <= move_count + 8'd1;
                    remaining  <= remaining - 8'd1;
                    if (remaining != 8'd1) begin
                        // Next move is drawn in the fire cycle so it has a full
                        // gap of settling before its own fire.
                        move  <= move_t'(lfsr_q[2:0]);
                        timer <= TIMER_RELOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mux: user pass-through unless the sequencer owns the grid
    // ------------------------------------------------------------------
    always_comb begin
        row_column = user_error ? '0 : user_row_column;
        x_nRow     = user_nRow;
        fire       = user_fire;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_GAP, ST_FIRE: begin
                row_column = line_onehot(move.idx);
                x_nRow     = move.x_nrow;
                fire       = (state == ST_FIRE);
                busy       = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_scramble_sequencer.sv
// Directed bench for scramble_sequencer: pass-through, paced scramble, lockout, zero moves, reset replay.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_scramble_sequencer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] user_row_column;
    logic       user_nRow;
    logic       user_fire;
    logic       user_error;

    logic [3:0] row_column;
    logic       x_nRow;
    logic       fire;
    logic       busy;
    logic       done;
    logic [7:0] move_count;

    logic [3:0] z_row_column;
    logic       z_x_nRow;
    logic       z_fire;
    logic       z_busy;
    logic       z_done;
    logic [7:0] z_move_count;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] lf_model;
    logic [2:0]  cur_seq [4];
    logic [2:0]  seq_a   [4];

    scramble_sequencer #(
        .MOVES       (4),
        .STEP_CYCLES (3),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .user_row_column (user_row_column),
        .user_nRow       (user_nRow),
        .user_fire       (user_fire),
        .user_error      (user_error),
        .row_column      (row_column),
        .x_nRow          (x_nRow),
        .fire            (fire),
        .busy            (busy),
        .done            (done),
        .move_count      (move_count)
    );

    scramble_sequencer #(
        .MOVES       (0),
        .STEP_CYCLES (3),
        .LFSR_SEED   (SEED)
    ) dut_zero (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .user_row_column (user_row_column),
        .user_nRow       (user_nRow),
        .user_fire       (user_fire),
        .user_error      (user_error),
        .row_column      (z_row_column),
        .x_nRow          (z_x_nRow),
        .fire            (z_fire),
        .busy            (z_busy),
        .done            (z_done),
        .move_count      (z_move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: value during a cycle equals the DUT LFSR in that cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset) lf_model <= SEED;
        else        lf_model <= {1'b0, lf_model[15:1]} ^ (lf_model[0] ? 16'hB400 : 16'h0000);
    end

    function automatic logic [3:0] oh4(input logic [1:0] i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic chk_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] pass_exp();
        return {(user_error ? 4'b0000 : user_row_column), user_nRow, user_fire};
    endfunction

    // Entered just after a rising edge; asserts reset mid-cycle, checks the
    // async response, then releases at a fixed offset so scrambles replay.
    task automatic apply_reset();
        #1 reset = 1'b0;
        #1;
        chk_vec("rst_busy",  16'(busy), 16'h0);
        chk_vec("rst_done",  16'(done), 16'h0);
        chk_vec("rst_count", 16'(move_count), 16'h0);
        chk_vec("rst_pass",  16'({row_column, x_nRow, fire}), 16'(pass_exp()));
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // MOVES=4, STEP_CYCLES=3: fire in cycles 4,8,12,16, done in 17.
    task automatic run_scramble(input bit disturb, input bit chk_zero);
        logic [2:0] mv;
        int         n;
        logic       exp_busy;
        logic       exp_fire;
        n     = 0;
        start = 1'b1;
        mv    = lf_model[2:0];
        @(posedge clk);
        #1;
        for (int t = 1; t <= 18; t++) begin
            start = disturb && (t == 6 || t == 17);
            if (disturb) begin
                user_row_column = 4'(t * 5);
                user_nRow       = t[1];
                user_fire       = ~t[0];
                user_error      = (t % 3 == 0);
            end
            #1;
            exp_busy = (t <= 16);
            exp_fire = exp_busy && (t % 4 == 0);
            chk_vec("busy", 16'(busy), 16'(exp_busy));
            chk_vec("done", 16'(done), 16'(t == 17));
            if (exp_busy) begin
                chk_vec("move", 16'({row_column, x_nRow, fire}),
                        16'({oh4(mv[1:0]), mv[2], exp_fire}));
                chk_vec("count", 16'(move_count), 16'((t - 1) / 4));
                if (exp_fire) begin
                    chk_vec("onehot", 16'($countones(row_column)), 16'd1);
                    if (n < 4) cur_seq[n] = mv;
                    n++;
                    mv = lf_model[2:0];
                end
            end else begin
                chk_vec("pass_after", 16'({row_column, x_nRow, fire}), 16'(pass_exp()));
                chk_vec("final_count", 16'(move_count), 16'd4);
            end
            if (chk_zero && t <= 2) begin
                chk_vec("zero_done", 16'(z_done), 16'(t == 1));
                chk_vec("zero_busy", 16'(z_busy), 16'h0);
                chk_vec("zero_out",  16'({z_row_column, z_x_nRow, z_fire}), 16'(pass_exp()));
                chk_vec("zero_cnt",  16'(z_move_count), 16'h0);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk_vec("fires_seen", 16'(n), 16'd4);
    endtask

    initial begin
        reset           = 1'b0;
        start           = 1'b0;
        user_row_column = 4'b0000;
        user_nRow       = 1'b0;
        user_fire       = 1'b0;
        user_error      = 1'b0;

        #1;
        chk_vec("init_busy",  16'(busy), 16'h0);
        chk_vec("init_done",  16'(done), 16'h0);
        chk_vec("init_count", 16'(move_count), 16'h0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // Pass-through in idle.
        user_row_column = 4'b0100; user_nRow = 1'b1; user_fire = 1'b1;
        #1 chk_vec("pt_basic", 16'({row_column, x_nRow, fire}), 16'b0100_1_1);
        user_error = 1'b1;
        #1 chk_vec("pt_error", 16'({row_column, x_nRow, fire}), 16'b0000_1_1);
        user_error = 1'b0; user_row_column = 4'b1000; user_nRow = 1'b0; user_fire = 1'b0;
        #1 chk_vec("pt_row",   16'({row_column, x_nRow, fire}), 16'b1000_0_0);
        user_row_column = 4'b0000;
        @(posedge clk);
        #1;

        // First scramble from a known LFSR offset (seed stepped 3 times = 389C).
        apply_reset();
        run_scramble(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) seq_a[i] = cur_seq[i];
        chk_vec("hand_move0", 16'(seq_a[0]), 16'h4);   // 389C[2:0] = 100
        chk_vec("hand_move1", 16'(seq_a[1]), 16'h1);   // ED89[2:0] = 001

        // Lockout: user inputs churn, start mid-scramble and in DONE.
        run_scramble(1'b1, 1'b0);
        chk_vec("idle_after_done_start", 16'(busy), 16'h0);

        // Reset during a GAP, then replay from the same offset.
        user_row_column = 4'b0010; user_nRow = 1'b0; user_fire = 1'b0; user_error = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 chk_vec("gap_busy", 16'(busy), 16'h1);
        apply_reset();
        run_scramble(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) chk_vec("replay", 16'(cur_seq[i]), 16'(seq_a[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/scramble_sequencer.md
# scramble_sequencer

Scramble move generator sitting directly upstream of the 4×4 cell grid's row/column select logic. In idle it passes the user's switch/button selection straight through. On a scramble request it takes over the grid's `row_column`/`x_nRow`/`fire` inputs and issues a fixed number of pseudo-random single-line moves at a paced rate. When finished it returns control to the user and pulses `done`.

## Interface
- `MOVES`, 32: number of random moves per scramble; range 0..255.
- `STEP_CYCLES`, 16: GAP length in clocks before each fire; range 1..65535.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  single-cycle scramble request, already edge-detected upstream.
- `user_row_column`  in  4  one-hot line select from the switch checker.
- `user_nRow`  in  1  0 = row, 1 = column.
- `user_fire`  in  1  debounced fire from the user.
- `user_error`  in  1  switch checker error; 1 = invalid selection.
- `row_column`  out  4  one-hot line select to the grid.
- `x_nRow`  out  1  row/column select to the grid.
- `fire`  out  1  fire to the grid.
- `busy`  out  1  high while the sequencer owns the grid.
- `done`  out  1  one-cycle pulse at scramble completion.
- `move_count`  out  8  moves issued since the last accepted `start`.

## Operation
- **States:** IDLE, GAP, FIRE, DONE.
- **IDLE:**
  - `row_column` = `user_error` ? 4'b0000 : `user_row_column`.
  - `x_nRow` = `user_nRow`; `fire` = `user_fire`.
  - `busy` = 0.
- **start in IDLE:**
  - Clear `move_count`, load `remaining` = `MOVES`, latch a move from the LFSR.
  - Go to GAP with the timer set to `STEP_CYCLES`-1.
  - If `MOVES` = 0, go straight to DONE instead.
- **GAP:**
  - Drive the latched move with `fire` = 0.
  - Decrement the timer; on timer = 0, go to FIRE.
- **FIRE:**
  - Drive the latched move with `fire` = 1 for exactly one cycle.
  - Increment `move_count` and decrement `remaining`.
  - If `remaining` was 1, go to DONE. Otherwise latch a new move, reload the timer and go to GAP.
- **DONE:** `done` = 1, `busy` = 0, outputs in pass-through; next state IDLE.
- **Move encoding** (from LFSR bits [2:0] at latch time):
  - `x_nRow` = bit2.
  - `row_column` = one-hot of bits[1:0] (00→0001, 01→0010, 10→0100, 11→1000).
- **LFSR:**
  - 16-bit Galois, taps 16'hB400.
  - Steps every clock in every state, so the scramble depends on when the user presses `start`.
  - Reset value is `LFSR_SEED`.
- **While busy:** `user_fire`, `user_row_column`, `user_nRow`, `user_error` and `start` are all ignored.
- **Reset at any time:**
  - State returns to IDLE immediately (asynchronous).
  - `busy` = 0, `done` = 0, `move_count` = 0, LFSR = seed, timer = 0.
  - Grid outputs follow pass-through of the user inputs.

## Timing
- `start` sampled at edge 0 → `busy` = 1 from cycle 1; GAP occupies cycles 1..`STEP_CYCLES`.
- First `fire` is high in cycle `STEP_CYCLES`+1.
- Each move lasts `STEP_CYCLES`+1 cycles, and the selection is stable for ≥ `STEP_CYCLES` cycles before its fire cycle.
- `busy` is high for `MOVES`×(`STEP_CYCLES`+1) cycles.
- `done` is high the cycle after the last FIRE; pass-through resumes in that same cycle.
- `move_count` updates on the edge ending each FIRE cycle.
- `start` asserted in the same cycle as DONE is ignored; a new scramble needs `start` in IDLE.
- All state, timer, counter and LFSR are registered. Grid outputs are a combinational mux of registered state and the user inputs, with no added latency in pass-through.

## Structure
- **Shared `game_pkg`:**
  - State enum: IDLE/GAP/FIRE/DONE.
  - `LINE_W` = 4.
  - LFSR tap constant 16'hB400.
  - One-hot decode function shared with the grid select logic.
- **Sub-module `lfsr16`:**
  - Parameter: seed.
  - Ports: `clk`, `reset` (active-low async), `q[15:0]`.
- Sequencer FSM, timer, `remaining` and `move_count` stay in this module.

## Test plan
- **Pass-through:** idle, `user_row_column`=0100, `user_nRow`=1, `user_fire`=1 → outputs 0100/1/1. Set `user_error`=1 → `row_column`=0000.
- **Default scramble:** `MOVES`=4, `STEP_CYCLES`=3, pulse `start`.
  - `fire` high exactly in cycles 4, 8, 12, 16; `done` in cycle 17.
  - `move_count` ends at 4; `busy` high for 16 cycles.
  - Each `row_column` is one-hot and matches the model LFSR bits.
- **User inputs locked out:** toggle `user_fire` and `user_row_column` during the scramble → grid outputs unaffected; `start` mid-scramble does not restart it and `move_count` keeps incrementing.
- **Zero moves:** `MOVES`=0, `start` → `done` pulse in cycle 1, no `fire`, `busy` never high.
- **Reset mid-scramble:** drive `reset`=0 during a GAP → same cycle `busy`=0 and pass-through active. After release, LFSR restarts from the seed and the second scramble reproduces the first's move sequence when `start` is at the same cycle offset.
